// File: rtl/mem_defines.sv
// Shared memory-interface definitions: AXI-Lite master states and
// response codes used by the CPU-side bus master.
package mem_defines;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA
  } axil_master_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cpu_master.sv
// CPU memory port to AXI-Lite master bridge.
// One transaction in flight; misaligned requests fail locally.
module axil_cpu_master
  import mem_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_be,
  output logic                  mem_ready,
  output logic                  mem_done,
  output logic                  mem_err,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(STRB_WIDTH - 1);

  axil_master_state_t state, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] be_q;
  logic                  we_q;
  logic                  instr_q;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic accept;
  logic misalign;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign mem_ready = (state == IDLE);
  assign accept    = mem_req && mem_ready;
  assign misalign  = |(mem_addr & AMASK);

  assign mem_done  = done_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_awprot  = {instr_q, 2'b00};
  assign m_axil_arprot  = {instr_q, 2'b00};
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = be_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_bready  = we_q &&
    (state == WRITE || state == WRESP);
  assign m_axil_rready  = !we_q &&
    (state == RADDR || state == RDATA);

  assign aw_hs = awvalid_q && m_axil_awready;
  assign w_hs  = wvalid_q && m_axil_wready;
  assign b_hs  = m_axil_bready && m_axil_bvalid;
  assign ar_hs = arvalid_q && m_axil_arready;
  assign r_hs  = m_axil_rready && m_axil_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      instr_q   <= 1'b0;
    end else begin
      state     <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        be_q    <= mem_be;
        we_q    <= mem_we;
        instr_q <= mem_instr;
      end
    end
  end

  always_comb begin
    state_d   = state;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misalign) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (mem_we) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        // B may land in the same cycle as the last AW/W beat
        if (b_hs) begin
          state_d   = IDLE;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = (m_axil_bresp != RESP_OKAY);
        end else if (!awvalid_d && !wvalid_d) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (m_axil_bresp != RESP_OKAY);
        end
      end
      RADDR: begin
        if (ar_hs) arvalid_d = 1'b0;
        if (r_hs) begin
          state_d   = IDLE;
          arvalid_d = 1'b0;
          done_d    = 1'b1;
          err_d     = (m_axil_rresp != RESP_OKAY);
          rdata_d   = m_axil_rdata;
        end else if (ar_hs) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (m_axil_rresp != RESP_OKAY);
          rdata_d = m_axil_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_cpu_master.sv
// Bench for axil_cpu_master: RAM-like slave plus stalling/error
// slave behaviours selected by the mode variable.
module tb_axil_cpu_master;
  import mem_defines::*;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_instr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_done, mem_err;
  logic [31:0] mem_rdata;
  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic        m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  axil_cpu_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_err(mem_err),
    .mem_rdata(mem_rdata),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: mode 0 behaves like axil_ram (PIPELINE_OUTPUT=0),
  // mode 1 delays AR then returns SLVERR, mode 2 splits AW/W
  // and never answers reads.
  logic [31:0] mem [0:255];
  int ar_wait, r_wait, wcnt;
  logic r_pend, wr_taken;

  initial for (int k = 0; k < 256; k++) mem[k] = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_axil_awready <= 1'b0;
      m_axil_wready  <= 1'b0;
      m_axil_bvalid  <= 1'b0;
      m_axil_bresp   <= 2'b00;
      m_axil_arready <= 1'b0;
      m_axil_rvalid  <= 1'b0;
      m_axil_rresp   <= 2'b00;
      m_axil_rdata   <= 32'h0;
      ar_wait <= 0; r_wait <= 0; wcnt <= 0;
      r_pend <= 1'b0; wr_taken <= 1'b0;
    end else begin
      m_axil_awready <= 1'b0;
      m_axil_wready  <= 1'b0;
      m_axil_arready <= 1'b0;
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
      if (mode == 0) begin
        if (m_axil_awvalid && m_axil_wvalid &&
            (!m_axil_bvalid || m_axil_bready) &&
            !m_axil_awready && !m_axil_wready) begin
          for (int b = 0; b < 4; b++)
            if (m_axil_wstrb[b])
              mem[m_axil_awaddr[9:2]][8*b +: 8] <= m_axil_wdata[8*b +: 8];
          m_axil_awready <= 1'b1;
          m_axil_wready  <= 1'b1;
          m_axil_bvalid  <= 1'b1;
          m_axil_bresp   <= RESP_OKAY;
        end
        if (m_axil_arvalid && (!m_axil_rvalid || m_axil_rready) &&
            !m_axil_arready) begin
          m_axil_arready <= 1'b1;
          m_axil_rvalid  <= 1'b1;
          m_axil_rdata   <= mem[m_axil_araddr[9:2]];
          m_axil_rresp   <= RESP_OKAY;
        end
      end else if (mode == 1) begin
        if (m_axil_arvalid && !m_axil_arready) begin
          if (ar_wait == 4) begin
            m_axil_arready <= 1'b1;
            ar_wait <= 0;
            r_pend  <= 1'b1;
            r_wait  <= 0;
          end else begin
            ar_wait <= ar_wait + 1;
          end
        end
        if (r_pend) begin
          if (r_wait == 2) begin
            m_axil_rvalid <= 1'b1;
            m_axil_rresp  <= RESP_SLVERR;
            m_axil_rdata  <= 32'hBAD0_BAD0;
            r_pend <= 1'b0;
          end else begin
            r_wait <= r_wait + 1;
          end
        end
      end else begin
        if (m_axil_wvalid && !m_axil_bvalid && !wr_taken) begin
          wcnt <= wcnt + 1;
          if (wcnt == 1) m_axil_awready <= 1'b1;
          if (wcnt == 3) m_axil_wready <= 1'b1;
        end
        if (m_axil_wvalid && m_axil_wready) begin
          wr_taken <= 1'b1;
          m_axil_bvalid <= 1'b1;
          m_axil_bresp  <= RESP_OKAY;
        end
        if (m_axil_bvalid && m_axil_bready) begin
          wr_taken <= 1'b0;
          wcnt <= 0;
        end
        if (m_axil_arvalid && !m_axil_arready)
          m_axil_arready <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction from acceptance to mem_done, watching the bus.
  task automatic txn(input logic we, input logic instr,
                     input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output int lat,
                     output logic err, output logic anyv,
                     output logic bad, output logic split);
    logic paw, pw, par;
    lat = 0; err = 1'b0; anyv = 1'b0; bad = 1'b0; split = 1'b0;
    paw = 1'b0; pw = 1'b0; par = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_instr = instr;
    mem_addr = addr; mem_wdata = wd; mem_be = be;
    if (!mem_ready) bad = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) anyv = 1'b1;
      if ((paw && !m_axil_awvalid) || (pw && !m_axil_wvalid) ||
          (par && !m_axil_arvalid)) bad = 1'b1;
      if (m_axil_awvalid && (m_axil_awaddr !== addr ||
          m_axil_awprot !== {instr, 2'b00})) bad = 1'b1;
      if (m_axil_wvalid && (m_axil_wdata !== wd ||
          m_axil_wstrb !== be)) bad = 1'b1;
      if (m_axil_arvalid && (m_axil_araddr !== addr ||
          m_axil_arprot !== {instr, 2'b00})) bad = 1'b1;
      if (!m_axil_awvalid && m_axil_wvalid) split = 1'b1;
      if (mem_done) begin
        lat = c;
        err = mem_err;
        break;
      end
      paw = m_axil_awvalid && !m_axil_awready;
      pw  = m_axil_wvalid && !m_axil_wready;
      par = m_axil_arvalid && !m_axil_arready;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        we;
    logic        instr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic we, logic instr, logic [15:0] a,
                              logic [31:0] d, logic [3:0] be, int lat,
                              logic err, logic [31:0] rd);
    vec_t v;
    v.we = we; v.instr = instr; v.addr = a; v.wdata = d; v.be = be;
    v.lat = lat; v.err = err; v.rdata = rd;
    return v;
  endfunction

  task automatic set_op(input int i);
    mem_we    = (i % 2 == 0);
    mem_instr = 1'b0;
    mem_addr  = 16'h0080 + 16'(4 * (i / 2));
    mem_wdata = 32'hA500_0000 | 32'(i);
    mem_be    = 4'hF;
  endtask

  initial begin
    int lat, dn;
    logic err, anyv, bad, split;
    vecs[0]  = mk(1, 0, 16'h0010, 32'hDEADBEEF, 4'hF, 3, 0, 32'h0);
    vecs[1]  = mk(0, 0, 16'h0010, 32'h0, 4'hF, 3, 0, 32'hDEADBEEF);
    vecs[2]  = mk(1, 0, 16'h0020, 32'h11223344, 4'hF, 3, 0, 32'h0);
    vecs[3]  = mk(1, 0, 16'h0020, 32'h0000AB00, 4'h2, 3, 0, 32'h0);
    vecs[4]  = mk(0, 0, 16'h0020, 32'h0, 4'hF, 3, 0, 32'h1122AB44);
    vecs[5]  = mk(1, 0, 16'h0030, 32'h55667788, 4'hF, 3, 0, 32'h0);
    vecs[6]  = mk(1, 0, 16'h0030, 32'hFFFFFFFF, 4'h0, 3, 0, 32'h0);
    vecs[7]  = mk(0, 0, 16'h0030, 32'h0, 4'hF, 3, 0, 32'h55667788);
    vecs[8]  = mk(0, 0, 16'h0006, 32'h0, 4'hF, 1, 1, 32'h55667788);
    vecs[9]  = mk(1, 0, 16'h0013, 32'h12345678, 4'hF, 1, 1, 32'h0);
    vecs[10] = mk(0, 1, 16'h0010, 32'h0, 4'hF, 3, 0, 32'hDEADBEEF);
    vecs[11] = mk(1, 0, 16'h0020, 32'hAA0000BB, 4'h9, 3, 0, 32'h0);

    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_instr = 1'b0;
    mem_addr = 16'h0; mem_wdata = 32'h0; mem_be = 4'h0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'h0, mem_ready}, 32'h1);
    check("rst done", {31'h0, mem_done}, 32'h0);
    check("rst err", {31'h0, mem_err}, 32'h0);
    check("rst rdata", mem_rdata, 32'h0);
    check("rst valids",
          {29'h0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 32'h0);
    check("rst readies",
          {30'h0, m_axil_bready, m_axil_rready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].we, vecs[i].instr, vecs[i].addr, vecs[i].wdata,
          vecs[i].be, lat, err, anyv, bad, split);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vecs[i].err});
      check($sformatf("v%0d bus", i), {31'h0, bad}, 32'h0);
      check($sformatf("v%0d traffic", i), {31'h0, anyv},
            {31'h0, (vecs[i].lat != 1)});
      if (!vecs[i].we)
        check($sformatf("v%0d rdata", i), mem_rdata, vecs[i].rdata);
      @(posedge clk); #1;
      check($sformatf("v%0d pulse", i), {31'h0, mem_done}, 32'h0);
    end
    txn(0, 0, 16'h0020, 32'h0, 4'hF, lat, err, anyv, bad, split);
    check("be9 readback", mem_rdata, 32'hAA22ABBB);

    // Delayed AR with SLVERR read response
    mode = 1;
    txn(0, 0, 16'h0040, 32'h0, 4'hF, lat, err, anyv, bad, split);
    check("slverr latency", 32'(lat), 32'd10);
    check("slverr err", {31'h0, err}, 32'h1);
    check("slverr ar hold", {31'h0, bad}, 32'h0);
    check("slverr rdata", mem_rdata, 32'hBAD0BAD0);
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_done) dn++;
    end
    check("slverr single done", 32'(dn), 32'd0);

    // AW accepted two cycles ahead of W
    mode = 2;
    txn(1, 0, 16'h0050, 32'hCAFEF00D, 4'hF, lat, err, anyv, bad, split);
    check("split latency", 32'(lat), 32'd7);
    check("split err", {31'h0, err}, 32'h0);
    check("split hold", {31'h0, bad}, 32'h0);
    check("split seen", {31'h0, split}, 32'h1);

    // Reset while waiting in RDATA
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0050;
    @(posedge clk); #1;
    mem_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rdata wait", {30'h0, m_axil_arvalid, m_axil_rready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst valids",
          {29'h0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 32'h0);
    check("midrst readies", {30'h0, m_axil_bready, m_axil_rready}, 32'h0);
    check("midrst ready", {31'h0, mem_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_done) dn++;
    end
    check("midrst no done", 32'(dn), 32'd0);

    // Back-to-back alternating writes/reads, mem_req held high
    @(negedge clk);
    set_op(0);
    mem_req = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        if (mem_done) begin
          lat = c;
          break;
        end
        @(posedge clk); #1;
      end
      check($sformatf("b2b%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("b2b%0d err", i), {31'h0, mem_err}, 32'h0);
      check($sformatf("b2b%0d ready", i), {31'h0, mem_ready}, 32'h1);
      if (i % 2 == 1)
        check($sformatf("b2b%0d rdata", i), mem_rdata,
              32'hA500_0000 | 32'(i - 1));
      if (i < 9) begin
        set_op(i + 1);
        @(posedge clk); #1;
      end else begin
        mem_req = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
